// File: rtl/fsm3_pkg.sv
// rtl/fsm3_pkg.sv - shared types, constants and transition table for the fsm3 "101" detector link
package fsm3_pkg;

    localparam int A = 0;
    localparam int B = 1;
    localparam int C = 2;
    localparam int D = 3;

    typedef logic [3:0] fsm3_state_t;

    localparam fsm3_state_t FSM3_RESET_STATE = 4'b0001;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ctrl_state_t;

    // One-hot "101" detector: A=no progress, B=seen 1, C=seen 10, D=seen 101
    function automatic fsm3_state_t fsm3_next(input fsm3_state_t state, input logic in_bit);
        fsm3_state_t nxt;
        nxt    = '0;
        nxt[A] = ~in_bit & (state[A] | state[C]);
        nxt[B] =  in_bit & (state[A] | state[B] | state[D]);
        nxt[C] = ~in_bit & (state[B] | state[D]);
        nxt[D] =  in_bit &  state[C];
        return nxt;
    endfunction

endpackage

// File: rtl/fsm3_onehot_next.sv
// rtl/fsm3_onehot_next.sv - combinational next state and match output of the one-hot detector
module fsm3_onehot_next
    import fsm3_pkg::*;
(
    input  logic [3:0] state,
    input  logic       in_bit,
    output logic [3:0] next_state,
    output logic       out
);

    assign next_state = fsm3_next(state, in_bit);
    assign out        = state[C] & in_bit;

endmodule

// File: rtl/fsm3_serial_tx.sv
// rtl/fsm3_serial_tx.sv - MSB-first serializer with a mirror of the far-end "101" detector
module fsm3_serial_tx
    import fsm3_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             last,
    output logic [3:0]       det_state,
    output logic             match,
    output logic [CNT_W-1:0] match_count
);

    localparam int CW = $clog2(WIDTH);

    ctrl_state_t      state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic             ser_out_q, ser_out_d;
    logic             ser_valid_q, ser_valid_d;
    logic             last_q, last_d;
    fsm3_state_t      det_q, det_d, det_next;
    logic             det_out;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             accept;

    fsm3_onehot_next u_mirror (
        .state      (det_q),
        .in_bit     (ser_out_q),
        .next_state (det_next),
        .out        (det_out)
    );

    assign in_ready    = (state_q == IDLE) || ((state_q == SHIFT) && last_q);
    assign accept      = in_valid && in_ready;
    assign match       = ser_valid_q && det_out;
    assign ser_out     = ser_out_q;
    assign ser_valid   = ser_valid_q;
    assign last        = last_q;
    assign det_state   = det_q;
    assign match_count = cnt_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        ser_out_d   = ser_out_q;
        ser_valid_d = ser_valid_q;
        last_d      = last_q;
        det_d       = det_q;
        cnt_d       = cnt_q;

        // Accept wins over the end of a word so back-to-back words leave no gap
        if (accept) begin
            state_d     = SHIFT;
            ser_out_d   = in_data[WIDTH-1];
            shift_d     = {in_data[WIDTH-2:0], 1'b0};
            bit_cnt_d   = CW'(WIDTH - 1);
            ser_valid_d = 1'b1;
            last_d      = 1'b0;
        end else if (state_q == SHIFT) begin
            if (last_q) begin
                state_d     = IDLE;
                ser_out_d   = 1'b0;
                ser_valid_d = 1'b0;
                last_d      = 1'b0;
            end else begin
                ser_out_d = shift_q[WIDTH-1];
                shift_d   = shift_q << 1;
                bit_cnt_d = bit_cnt_q - 1'b1;
                last_d    = (bit_cnt_q == CW'(1));
            end
        end

        if (ser_valid_q) begin
            det_d = det_next;
        end
        if (match && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            ser_out_q   <= 1'b0;
            ser_valid_q <= 1'b0;
            last_q      <= 1'b0;
            det_q       <= FSM3_RESET_STATE;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            ser_out_q   <= ser_out_d;
            ser_valid_q <= ser_valid_d;
            last_q      <= last_d;
            det_q       <= det_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fsm3_serial_tx.sv
// tb/tb_fsm3_serial_tx.sv - self-checking bench for fsm3_serial_tx against a bit-history model
module tb_fsm3_serial_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [7:0] in_data;

    logic       in_ready, ser_out, ser_valid, last, match;
    logic [3:0] det_state;
    logic [7:0] match_count;

    logic       in_ready2, ser_out2, ser_valid2, last2, match2;
    logic [3:0] det_state2;
    logic [1:0] match_count2;

    always #5 clk = ~clk;

    fsm3_serial_tx #(.WIDTH(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .ser_out(ser_out), .ser_valid(ser_valid), .last(last),
        .det_state(det_state), .match(match), .match_count(match_count)
    );

    fsm3_serial_tx #(.WIDTH(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready2), .ser_out(ser_out2), .ser_valid(ser_valid2), .last(last2),
        .det_state(det_state2), .match(match2), .match_count(match_count2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: queue of bits still to appear on the wire plus the last three bits sent
    logic       q_bit[$];
    logic       q_last[$];
    logic [2:0] hist       = 3'b000;
    int         raw_cnt    = 0;
    bit         model_live = 1'b0;

    function automatic logic [3:0] det_exp(input logic [2:0] h);
        if (h[0])                return (h == 3'b101) ? 4'b1000 : 4'b0010;
        else if (h[1:0] == 2'b10) return 4'b0100;
        else                      return 4'b0001;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            if (reset) begin
                q_bit.delete();
                q_last.delete();
                hist       = 3'b000;
                raw_cnt    = 0;
                model_live = 1'b1;
            end else begin
                bit rdy;
                rdy = (q_bit.size() <= 1);
                if (q_bit.size() > 0) begin
                    if (hist[1:0] == 2'b10 && q_bit[0]) raw_cnt++;
                    hist = {hist[1:0], q_bit[0]};
                    void'(q_bit.pop_front());
                    void'(q_last.pop_front());
                end
                if (in_valid && rdy) begin
                    for (int i = 7; i >= 0; i--) begin
                        q_bit.push_back(in_data[i]);
                        q_last.push_back(i == 0);
                    end
                end
            end
        end
    end

    logic [31:0] cap, mcap, lcap;
    int          nbits, cyc, first_cyc, last_cyc, m2pulses;
    logic [13:0] c2seq;
    logic        prev_match2 = 1'b0;

    initial begin
        cyc = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (model_live) begin
                bit exp_v;
                exp_v = (q_bit.size() > 0);
                chk("ser_valid", ser_valid, exp_v);
                chk("in_ready", in_ready, q_bit.size() <= 1);
                chk("det_state", det_state, det_exp(hist));
                chk("onehot", $onehot(det_state), 1);
                chk("match", match, exp_v && hist[1:0] == 2'b10 && q_bit[0]);
                chk("match_count", match_count, (raw_cnt > 255) ? 255 : raw_cnt);
                chk("match_count_w2", match_count2, (raw_cnt > 3) ? 3 : raw_cnt);
                chk("match_w2", match2, match);
                if (exp_v) begin
                    chk("ser_out", ser_out, q_bit[0]);
                    chk("last", last, q_last[0]);
                end
                if (ser_valid) begin
                    if (nbits == 0) first_cyc = cyc;
                    last_cyc = cyc;
                    nbits++;
                    cap  = {cap[30:0], ser_out};
                    mcap = {mcap[30:0], match};
                    lcap = {lcap[30:0], last};
                end
                if (prev_match2) c2seq = {c2seq[11:0], match_count2};
                if (match2) m2pulses++;
                prev_match2 = match2;
            end
        end
    end

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        cap = '0; mcap = '0; lcap = '0; nbits = 0; m2pulses = 0; c2seq = '0;
        first_cyc = 0; last_cyc = 0;
    endtask

    task automatic send_word(input logic [7:0] w, input bit keep);
        int n;
        in_valid = 1'b1;
        in_data  = w;
        n = 0;
        while (!in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("accept_wait", in_ready, 1);
        @(negedge clk);
        if (!keep) begin
            in_valid = 1'b0;
            in_data  = ~w;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (ser_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait", ser_valid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        @(negedge clk);

        do_reset();
        chk("t1_ser_valid", ser_valid, 0);
        chk("t1_ser_out", ser_out, 0);
        chk("t1_last", last, 0);
        chk("t1_det", det_state, 4'b0001);
        chk("t1_count", match_count, 0);
        chk("t1_in_ready", in_ready, 1);
        reset = 1'b0;

        send_word(8'hA8, 0);
        wait_idle();
        chk("t2_nbits", nbits, 8);
        chk("t2_bits", cap[7:0], 8'hA8);
        chk("t2_match_pos", mcap[7:0], 8'b0010_1000);
        chk("t2_last_pos", lcap[7:0], 8'b0000_0001);
        chk("t2_det", det_state, 4'b0001);
        chk("t2_count", match_count, 2);

        do_reset();
        reset = 1'b0;
        send_word(8'hA5, 1);
        send_word(8'h40, 0);
        wait_idle();
        chk("t3_nbits", nbits, 16);
        chk("t3_no_gap", last_cyc - first_cyc + 1, 16);
        chk("t3_bits", cap[15:0], 16'hA540);
        chk("t3_match_pos", mcap[15:0], 16'h2140);
        chk("t3_count", match_count, 3);

        do_reset();
        reset = 1'b0;
        send_word(8'h02, 0);
        wait_idle();
        for (int i = 0; i < 5; i++) begin
            chk("t4_gap_det", det_state, 4'b0100);
            @(negedge clk);
        end
        send_word(8'h80, 0);
        chk("t4_first_bit", ser_out, 1);
        chk("t4_first_match", match, 1);
        wait_idle();
        chk("t4_count", match_count, 1);

        do_reset();
        reset = 1'b0;
        send_word(8'hFF, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_ser_valid", ser_valid, 0);
        chk("t5_det", det_state, 4'b0001);
        chk("t5_count", match_count, 0);
        chk("t5_in_ready", in_ready, 1);
        chk("t5_nbits_at_reset", nbits, 4);
        reset = 1'b0;
        repeat (10) @(negedge clk);
        chk("t5_no_more_bits", nbits, 4);

        do_reset();
        reset = 1'b0;
        send_word(8'hAA, 1);
        send_word(8'hAA, 0);
        wait_idle();
        chk("t6_pulses", m2pulses, 7);
        chk("t6_count_seq", c2seq, 14'h1BFF);
        chk("t6_count_w2", match_count2, 3);
        chk("t6_count_w8", match_count, 7);

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
